alu_pipe_core: RTL and testbench

//  Parametrised, registered successor to the execute-stage ALU, sitting between decode and writeback/LSU.

---
 rtl/alu_pipe_core.sv | 256 +++++++++++++++++++++++++
 tb/tb_alu_pipe_core.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe_core.sv
// ============================================================================
// Module   : alu_pipe_core
// Purpose  : Registered execute-stage ALU. It accepts one operation per clock
//            through a valid/ready handshake. Results go to a one-entry output
//            slot that is held stable while the consumer stalls.
//            Single-cycle ops (integer, compare, branch, link) have latency 1.
//            Optional iterative multiply/divide ops (MUL, MULHU, DIVU, REMU)
//            are enabled by the ALU_MULDIV_EN macro. They take XLEN+1 clocks
//            from accept to result, and in_ready is low while they run.
// Config   : `define ALU_MULDIV_EN to build the muldiv unit. When it is left
//            undefined, ops 18-21 decode as unknown (result 0, latency 1).
// Ports    : clk, rst (async, active high)
//            in_valid/in_ready, op[4:0], a, b, pc  - operation input
//            out_valid/out_ready, result, branch_taken - result slot
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_pipe_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [XLEN-1:0] pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            branch_taken
);

  localparam int SHW = $clog2(XLEN);

  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_SUB   = 5'd1;
  localparam logic [4:0] OP_SLL   = 5'd2;
  localparam logic [4:0] OP_SLT   = 5'd3;
  localparam logic [4:0] OP_SLTU  = 5'd4;
  localparam logic [4:0] OP_XOR   = 5'd5;
  localparam logic [4:0] OP_SRL   = 5'd6;
  localparam logic [4:0] OP_SRA   = 5'd7;
  localparam logic [4:0] OP_OR    = 5'd8;
  localparam logic [4:0] OP_AND   = 5'd9;
  localparam logic [4:0] OP_PASSB = 5'd10;
  localparam logic [4:0] OP_BEQ   = 5'd11;
  localparam logic [4:0] OP_BNE   = 5'd12;
  localparam logic [4:0] OP_BLT   = 5'd13;
  localparam logic [4:0] OP_BGE   = 5'd14;
  localparam logic [4:0] OP_BLTU  = 5'd15;
  localparam logic [4:0] OP_BGEU  = 5'd16;
  localparam logic [4:0] OP_LINK  = 5'd17;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            br_q, br_d;

  logic            accept;
  logic            start_md;
  logic            md_done;
  logic [XLEN-1:0] md_res;

  logic [XLEN-1:0] alu_res;
  logic            alu_br;
  logic [SHW-1:0]  shamt;
  logic            lt_s, lt_u;

  assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // --------------------------------------------------------------------------
  // Single-cycle datapath
  // --------------------------------------------------------------------------
  assign shamt = b[SHW-1:0];
  assign lt_s  = $signed(a) < $signed(b);
  assign lt_u  = a < b;

  always_comb begin
    alu_res = '0;
    alu_br  = 1'b0;
    case (op)
      OP_ADD:   alu_res = a + b;
      OP_SUB:   alu_res = a - b;
      OP_SLL:   alu_res = a << shamt;
      OP_SLT:   alu_res = {{(XLEN-1){1'b0}}, lt_s};
      OP_SLTU:  alu_res = {{(XLEN-1){1'b0}}, lt_u};
      OP_XOR:   alu_res = a ^ b;
      OP_SRL:   alu_res = a >> shamt;
      OP_SRA:   alu_res = $signed(a) >>> shamt;
      OP_OR:    alu_res = a | b;
      OP_AND:   alu_res = a & b;
      OP_PASSB: alu_res = b;
      OP_BEQ:   alu_br  = (a == b);
      OP_BNE:   alu_br  = (a != b);
      OP_BLT:   alu_br  = lt_s;
      OP_BGE:   alu_br  = !lt_s;
      OP_BLTU:  alu_br  = lt_u;
      OP_BGEU:  alu_br  = !lt_u;
      OP_LINK:  alu_res = pc + XLEN'(4);
      default: begin
        alu_res = '0;
        alu_br  = 1'b0;
      end
    endcase
  end

`ifdef ALU_MULDIV_EN
  // --------------------------------------------------------------------------
  // Iterative multiply / restoring divide, one bit per clock.
  // hi_q/lo_q hold the high and low halves of the product for MUL/MULHU, and
  // the remainder and quotient for DIVU/REMU. Both start as {0, a}.
  // The ops that want the upper half (MULHU=19, REMU=21) are the odd ones.
  // --------------------------------------------------------------------------
  logic [SHW-1:0]  count_q, count_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] opnd_q, opnd_d;
  logic            is_div_q, is_div_d;
  logic            hi_sel_q, hi_sel_d;

  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic [XLEN:0]   div_trial;

  assign start_md = accept && (op >= 5'd18) && (op <= 5'd21);
  assign md_done  = (state_q == ST_DONE);
  assign md_res   = hi_sel_q ? hi_q : lo_q;

  assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
  assign div_shift = {hi_q, lo_q[XLEN-1]};
  assign div_trial = div_shift - {1'b0, opnd_q};

  always_comb begin
    count_d  = count_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    hi_sel_d = hi_sel_q;
    if (start_md) begin
      count_d  = '0;
      hi_d     = '0;
      lo_d     = a;
      opnd_d   = b;
      is_div_d = op[2];
      hi_sel_d = op[0];
    end else if (state_q == ST_BUSY) begin
      count_d = count_q + SHW'(1);
      if (is_div_q) begin
        // A non-negative trial difference means the divisor fits; restore otherwise.
        // A zero divisor always fits, which yields all-ones quotient and remainder = a.
        if (!div_trial[XLEN]) begin
          hi_d = div_trial[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], 1'b1};
        end else begin
          hi_d = div_shift[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], 1'b0};
        end
      end else begin
        hi_d = mul_sum[XLEN:1];
        lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      hi_sel_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      hi_sel_q <= hi_sel_d;
    end
  end
`else
  assign start_md = 1'b0;
  assign md_done  = 1'b0;
  assign md_res   = '0;
`endif

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
`ifdef ALU_MULDIV_EN
    case (state_q)
      ST_IDLE: if (start_md) state_d = ST_BUSY;
      ST_BUSY: if (count_q == SHW'(XLEN-1)) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
`endif
  end

  // --------------------------------------------------------------------------
  // Result slot. A completion and an accept never coincide because in_ready
  // is low outside IDLE. A new completion overrides a pop in the same cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    br_d        = br_q;
    if (md_done) begin
      out_valid_d = 1'b1;
      result_d    = md_res;
      br_d        = 1'b0;
    end else if (accept && !start_md) begin
      out_valid_d = 1'b1;
      result_d    = alu_res;
      br_d        = alu_br;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      br_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      br_q        <= br_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign result       = result_q;
  assign branch_taken = br_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_pipe_core.sv
// ============================================================================
// Module   : tb_alu_pipe_core
// Purpose  : Directed self-checking bench for alu_pipe_core (XLEN=32).
//            Muldiv vectors are compiled only with ALU_MULDIV_EN defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_pipe_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  op;
  logic [31:0] a, b, pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        branch_taken;

  int n_vec = 0;
  int n_err = 0;

  alu_pipe_core #(.XLEN(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .op           (op),
    .a            (a),
    .b            (b),
    .pc           (pc),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .branch_taken (branch_taken)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Present one single-cycle op with out_ready=1; called 1 time unit after a
  // rising edge and returns 1 time unit after the accepting edge.
  task automatic do_op(input logic [4:0] o, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] pcv, input logic [31:0] exp_res,
                       input logic exp_br, input string tag);
    op = o; a = av; b = bv; pc = pcv;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    chk({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_res"}, result, exp_res);
    chk({tag, "_br"},  {31'd0, branch_taken}, {31'd0, exp_br});
  endtask

`ifdef ALU_MULDIV_EN
  task automatic md_op(input logic [4:0] o, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] exp_res, input string tag);
    int lat;
    op = o; a = av; b = bv; pc = 32'd0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    chk({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    // operands changing mid-operation must not matter
    a = 32'hDEADBEEF; b = 32'h3; op = 5'd0;
    chk({tag, "_busy"}, {31'd0, in_ready}, 32'd0);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, 32'd33);
    chk({tag, "_res"}, result, exp_res);
    chk({tag, "_br"},  {31'd0, branch_taken}, 32'd0);
  endtask
`endif

  logic [31:0] expq[$];
  int          idx;
  int          pops;
  logic        acc;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op = 5'd0; a = '0; b = '0; pc = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld", {31'd0, out_valid}, 32'd0);
    chk("rst_res", result, 32'd0);
    chk("rst_br",  {31'd0, branch_taken}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_rdy", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // single-cycle ops, back to back at full rate
    do_op(5'd0,  32'hFFFFFFFF, 32'h1,        32'h0,   32'h00000000, 1'b0, "add_wrap");
    do_op(5'd1,  32'h5,        32'h7,        32'h0,   32'hFFFFFFFE, 1'b0, "sub");
    do_op(5'd2,  32'h1,        32'h21,       32'h0,   32'h00000002, 1'b0, "sll");
    do_op(5'd3,  32'hFFFFFFFF, 32'h1,        32'h0,   32'h00000001, 1'b0, "slt");
    do_op(5'd4,  32'h1,        32'hFFFFFFFF, 32'h0,   32'h00000001, 1'b0, "sltu");
    do_op(5'd5,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0,   32'h0FF00FF0, 1'b0, "xor");
    do_op(5'd6,  32'h80000000, 32'h4,        32'h0,   32'h08000000, 1'b0, "srl");
    do_op(5'd7,  32'h80000000, 32'h24,       32'h0,   32'hF8000000, 1'b0, "sra");
    do_op(5'd8,  32'h0F0F0000, 32'h000000F0, 32'h0,   32'h0F0F00F0, 1'b0, "or");
    do_op(5'd9,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0,   32'hF000F000, 1'b0, "and");
    do_op(5'd10, 32'h11111111, 32'h12345000, 32'h0,   32'h12345000, 1'b0, "passb");
    do_op(5'd11, 32'h5,        32'h5,        32'h0,   32'h0,        1'b1, "beq");
    do_op(5'd12, 32'h5,        32'h5,        32'h0,   32'h0,        1'b0, "bne");
    do_op(5'd13, 32'hFFFFFFFE, 32'h1,        32'h0,   32'h0,        1'b1, "blt");
    do_op(5'd14, 32'hFFFFFFFE, 32'h1,        32'h0,   32'h0,        1'b0, "bge");
    do_op(5'd15, 32'hFFFFFFFE, 32'h1,        32'h0,   32'h0,        1'b0, "bltu");
    do_op(5'd16, 32'hFFFFFFFE, 32'h1,        32'h0,   32'h0,        1'b1, "bgeu");
    do_op(5'd17, 32'h55,       32'h66,       32'h100, 32'h104,      1'b0, "link");
    do_op(5'd25, 32'h1,        32'h1,        32'h0,   32'h0,        1'b0, "unknown");
`ifndef ALU_MULDIV_EN
    do_op(5'd20, 32'd100,      32'd7,        32'h0,   32'h0,        1'b0, "divu_off");
`endif

    // empty the slot: out_ready with no new op clears out_valid
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("clear", {31'd0, out_valid}, 32'd0);

    // stall with out_ready=0 for four cycles, then drain
    idx = 0; pops = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      in_valid  = (idx < 3);
      op        = 5'd0;
      a         = 32'(10 * (idx + 1));
      b         = 32'd1;
      out_ready = (cyc >= 4);
      #2;
      acc = in_valid && in_ready;
      if (out_valid && !out_ready) begin
        if (expq.size() > 0) chk("stall_hold", result, expq[0]);
        else chk("stall_q", 32'd0, 32'd1);
        chk("stall_rdy", {31'd0, in_ready}, 32'd0);
      end
      if (out_valid && out_ready) begin
        if (expq.size() > 0) chk("drain", result, expq.pop_front());
        else chk("drain_extra", 32'd1, 32'd0);
        pops++;
      end
      @(posedge clk); #1;
      if (acc) begin
        expq.push_back(32'(10 * (idx + 1) + 1));
        idx++;
      end
    end
    in_valid = 1'b0;
    chk("drain_cnt", pops, 32'd3);
    chk("drain_left", expq.size(), 32'd0);
    chk("drain_clear", {31'd0, out_valid}, 32'd0);

    // async reset while a result is stalled in the slot
    op = 5'd0; a = 32'd7; b = 32'd8; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pre_rst_res", result, 32'd15);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_vld", {31'd0, out_valid}, 32'd0);
    chk("async_rst_res", result, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("post_rst_rdy", {31'd0, in_ready}, 32'd1);
    do_op(5'd0, 32'd2, 32'd3, 32'h0, 32'd5, 1'b0, "post_rst_add");

`ifdef ALU_MULDIV_EN
    md_op(5'd20, 32'd100,      32'd7,        32'd14,       "divu");
    md_op(5'd21, 32'd100,      32'd7,        32'd2,        "remu");
    md_op(5'd20, 32'd100,      32'd0,        32'hFFFFFFFF, "divu_z");
    md_op(5'd21, 32'd100,      32'd0,        32'd100,      "remu_z");
    md_op(5'd19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu");
    md_op(5'd18, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, "mul");
    md_op(5'd18, 32'd1234,     32'd5678,     32'd7006652,  "mul_small");

    // reset ten clocks into a DIVU
    op = 5'd20; a = 32'd100; b = 32'd7; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("md_rst_vld", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("md_rst_rdy", {31'd0, in_ready}, 32'd1);
    do_op(5'd0, 32'd40, 32'd2, 32'h0, 32'd42, 1'b0, "md_rst_add");
    // the abandoned divide must never show up
    out_ready = 1'b1;
    pops = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) pops++;
    end
    chk("md_rst_ghost", pops, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
